latch_write_sequencer: RTL and testbench

- Synchronous upstream driver for a bank of `DEPTH` transparent D latches, each `WIDTH` bits wide.
- Accepts write requests over a valid/ready handshake.
- Drives the shared latch data bus and one per-latch enable. Enables are one-hot, glitch-free and registered.
- Enforces programmable setup, open (transparent) and hold windows measured in clock cycles.
- Sits between the clocked control logic and the latch array. It is the only source of the latches' D and E inputs.

---
 rtl/latch_write_sequencer_pkg.sv | 21 ++
 rtl/latch_write_sequencer_if.sv | 22 ++
 rtl/latch_write_sequencer_phase_timer.sv | 24 ++
 rtl/latch_write_sequencer.sv | 77 +++++++
 tb/tb_latch_write_sequencer.sv | 121 ++++++++++++
 5 files changed

// File: rtl/latch_write_sequencer_pkg.sv
// latch_write_sequencer_pkg: shared FSM state type and width helpers for the latch write sequencer
//   state_e      : IDLE / SETUP / OPEN / HOLD
//   clog2        : ceiling log2
//   addr_w       : latch index width, at least 1
//   phase_cnt_w  : phase-counter width, clog2(max(S, O, H) + 1), at least 1
package latch_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic int addr_w(input int depth);
        return clog2(depth) < 1 ? 1 : clog2(depth);
    endfunction
    function automatic int phase_cnt_w(input int s, input int o, input int h);
        int m = s > o ? s : o;
        m = m > h ? m : h;
        return clog2(m + 1) < 1 ? 1 : clog2(m + 1);
    endfunction
endpackage

// File: rtl/latch_write_sequencer_if.sv
// latch_write_sequencer_if: write handshake plus latch-side bus of the sequencer
//   master : drives in_valid/in_addr/in_data, observes everything else
//   slave  : the sequencer itself
interface latch_write_sequencer_if import latch_ctrl_pkg::*; #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int AW = addr_w(DEPTH);
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_addr;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] latch_d;
    logic [DEPTH-1:0] latch_en;
    logic             busy;
    logic             wr_done;
    logic             wr_err;
    modport master (output in_valid, in_addr, in_data,
                    input  in_ready, latch_d, latch_en, busy, wr_done, wr_err);
    modport slave  (input  in_valid, in_addr, in_data,
                    output in_ready, latch_d, latch_en, busy, wr_done, wr_err);
endinterface

// File: rtl/latch_write_sequencer_phase_timer.sv
// phase_timer: loadable down-counter timing one FSM phase
//   clk, rst : clock, synchronous active-high reset
//   load_i   : load val_i (on entry to a phase)
//   val_i    : phase length in cycles
//   tc_o     : high in the last cycle of the loaded phase
module phase_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         tc_o
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb begin
        cnt_d = load_i ? val_i : cnt_q != '0 ? cnt_q - 1'b1 : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
    assign tc_o = cnt_q == W'(1);
endmodule

// File: rtl/latch_write_sequencer.sv
// latch_write_sequencer: sequences one write at a time into a bank of transparent latches
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave side of latch_write_sequencer_if (handshake in, latch D/E bus out,
//              busy / wr_done / wr_err status)
module latch_write_sequencer import latch_ctrl_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int SETUP_CYC = 1,
    parameter int OPEN_CYC  = 2,
    parameter int HOLD_CYC  = 1
) (
    input logic                    clk,
    input logic                    rst,
    latch_write_sequencer_if.slave bus
);
    localparam int AW = addr_w(DEPTH);
    localparam int CW = phase_cnt_w(SETUP_CYC, OPEN_CYC, HOLD_CYC);
    state_e           state_q, state_d;
    logic [AW-1:0]    addr_q, sel;
    logic             bad_q;
    logic [WIDTH-1:0] d_q;
    logic [DEPTH-1:0] en_q, en_d;
    logic             done_q, done_d, err_q;
    logic             accept, load, tc;
    logic [CW-1:0]    load_val;
    assign accept = bus.in_valid && state_q == IDLE;
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = SETUP_CYC > 0 ? SETUP : OPEN;
            SETUP:   if (tc) state_d = OPEN;
            OPEN:    if (tc) state_d = HOLD_CYC > 0 ? HOLD : IDLE;
            default: if (tc) state_d = IDLE;
        endcase
        load     = state_d != state_q && state_d != IDLE;
        load_val = state_d == SETUP ? CW'(SETUP_CYC) : state_d == OPEN ? CW'(OPEN_CYC) : CW'(HOLD_CYC);
        done_d   = state_q != IDLE && state_d == IDLE;
        // With no setup phase E rises on the accepting edge, so decode the live address then.
        sel      = accept ? bus.in_addr : addr_q;
        en_d     = '0;
        for (int i = 0; i < DEPTH; i++) en_d[i] = state_d == OPEN && sel == AW'(i);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            bad_q   <= 1'b0;
            d_q     <= '0;
            en_q    <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            en_q    <= en_d;
            done_q  <= done_d;
            err_q   <= done_d && bad_q;
            if (accept) begin
                addr_q <= bus.in_addr;
                bad_q  <= 32'(bus.in_addr) >= DEPTH;
                d_q    <= bus.in_data;
            end
        end
    end
    phase_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .val_i  (load_val),
        .tc_o   (tc)
    );
    assign bus.in_ready = state_q == IDLE;
    assign bus.busy     = state_q != IDLE;
    assign bus.latch_d  = d_q;
    assign bus.latch_en = en_q;
    assign bus.wr_done  = done_q;
    assign bus.wr_err   = err_q;
endmodule

// File: tb/tb_latch_write_sequencer.sv
// tb_latch_write_sequencer: random and directed writes into two sequencer configurations, checked against a write-timeline model
module tb_latch_write_sequencer;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid[2];
    logic [2:0] addr[2];
    logic [7:0] data[2];
    logic       rdy[2];
    int         total = 0;
    int         bad = 0;
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    // cfg 0: defaults (S=1, O=2, H=1, DEPTH=4); cfg 1: S=0, O=2, H=0, DEPTH=5 so addresses 5..7 are out of range
    for (genvar g = 0; g < 2; g++) begin : g_cfg
        localparam int S  = g == 1 ? 0 : 1;
        localparam int O  = 2;
        localparam int H  = g == 1 ? 0 : 1;
        localparam int D  = g == 1 ? 5 : 4;
        localparam int AW = g == 1 ? 3 : 2;
        localparam int T  = S + O + H;
        latch_write_sequencer_if #(.WIDTH(8), .DEPTH(D)) ifc ();
        latch_write_sequencer #(.WIDTH(8), .DEPTH(D), .SETUP_CYC(S), .OPEN_CYC(O), .HOLD_CYC(H)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc.slave)
        );
        assign ifc.in_valid = valid[g];
        assign ifc.in_addr  = addr[g][AW-1:0];
        assign ifc.in_data  = data[g];
        assign rdy[g]       = ifc.in_ready;
        // j = edges since acceptance (-1 when idle); write occupies j = 0..T-1, j = T is the done cycle
        int         j = -1;
        int         ma = 0;
        logic [7:0] md = 0;
        logic [7:0] dexp = 0;
        logic [7:0] q[D];
        logic [7:0] mem[D];
        bit         known[D];
        always @(posedge clk) begin
            if (rst) begin
                if (j >= S && j < T && ma < D) known[ma] = 0;
                j = -1;
                dexp = 0;
            end else if ((j < 0 || j == T) && valid[g]) begin
                j = 0;
                ma = int'(addr[g][AW-1:0]);
                md = data[g];
                dexp = data[g];
            end else if (j >= 0 && j < T) begin
                j++;
                if (j == T && ma < D) begin
                    mem[ma] = md;
                    known[ma] = 1;
                end
            end else j = -1;
        end
        always @(negedge clk) begin
            automatic logic [31:0] ee = (j >= S && j < S + O && ma < D) ? 32'(1) << ma : 32'(0);
            automatic bit dn = j == T;
            chk($sformatf("%0d.ready", g), ifc.in_ready, !(j >= 0 && j < T));
            chk($sformatf("%0d.busy", g), ifc.busy, j >= 0 && j < T);
            chk($sformatf("%0d.en", g), 32'(ifc.latch_en), ee);
            chk($sformatf("%0d.onehot", g), $countones(ifc.latch_en) <= 1, 1);
            chk($sformatf("%0d.d", g), ifc.latch_d, dexp);
            chk($sformatf("%0d.done", g), ifc.wr_done, dn);
            chk($sformatf("%0d.err", g), ifc.wr_err, dn && ma >= D);
            for (int i = 0; i < D; i++) if (ifc.latch_en[i]) q[i] = ifc.latch_d;
            if (dn) for (int i = 0; i < D; i++) if (known[i]) chk($sformatf("%0d.q%0d", g, i), q[i], mem[i]);
        end
    end
    task automatic send(input int g, input int a, input int d);
        valid[g] = 1'b1;
        addr[g] = 3'(a);
        data[g] = 8'(d);
        for (int n = 0; n < 40 && !rdy[g]; n++) @(negedge clk);
        chk("accept_wait", rdy[g], 1);
        @(negedge clk);
        valid[g] = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        valid = '{1'b0, 1'b0};
        addr = '{3'd0, 3'd0};
        data = '{8'd0, 8'd0};
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send(0, 2, 8'hA5);
        repeat (6) @(negedge clk);
        send(0, 0, 8'h11);
        send(0, 1, 8'h22);
        send(0, 3, 8'h33);
        repeat (6) @(negedge clk);
        send(0, 1, 8'h5A);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(0, 1, 8'h3C);
        repeat (6) @(negedge clk);
        send(1, 4, 8'h77);
        send(1, 5, 8'h99);
        send(1, 7, 8'h42);
        send(1, 0, 8'hC3);
        repeat (4) @(negedge clk);
        repeat (60) begin
            automatic int g = int'($urandom_range(0, 1));
            send(g, int'($urandom_range(0, g == 1 ? 7 : 3)), int'($urandom_range(0, 255)));
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        repeat (8) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
